seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Consumer end of the NIOS 32-bit 7-segment PIO export. Snapshots the packed word at frame
//  boundaries, decodes four nibbles, time-multiplexes a 4-digit common-anode display with
//  anti-ghost dead time, and applies per-digit blink, decimal points, colon and global enable.
// PARAMETERS
//  CLK_HZ       50_000_000  system clock frequency
//  DIGIT_HZ     4_000       digit-slot rate; SLOT = CLK_HZ/DIGIT_HZ cycles per digit
//  DEAD_CYCLES  64          all-anodes-off cycles at start of each slot; must be < SLOT
//  BLINK_HZ     2           blink rate; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
// PORTS
//  clk_clk        in   1   system clock
//  reset_reset_n  in   1   asynchronous active-low reset
//  pio_word       in   32  PIO export: [15:0] digits d3..d0 (nibble i = digit i),
//                          [19:16] dp[i], [23:20] blink[i], [24] colon, [25] enable, [31:26] ignored
//  seg_n          out  7   segments g..a, active-low
//  dp_n           out  1   decimal point, active-low
//  an_n           out  4   digit anodes, active-low, one-hot or all-off
//  frame_sync     out  1   one-cycle pulse when the shadow word is reloaded
// BEHAVIOUR
//  - Reset: seg_n=7'h7F, dp_n=1, an_n=4'hF, frame_sync=0, shadow=0, digit=0, phase=0, state=BLANK.
//  - Clock and reset are fixed: single clock clk_clk; reset_reset_n asynchronous, active-low.
//  - Slot counter 0..SLOT-1. FSM: BLANK for counts 0..DEAD_CYCLES-1, then DRIVE until SLOT-1.
//  - BLANK: an_n=4'hF, seg_n=7'h7F, dp_n=1. DRIVE: an_n[digit]=0, segments from the shadow word.
//  - At count SLOT-1: counter->0, digit->(digit+1) mod 4, state->BLANK.
//  - When digit wraps 3->0: shadow<=pio_word and frame_sync=1 for that cycle. No mid-frame tearing.
//  - All outputs are registered: pins reflect FSM/counter state one cycle later.
//  - Blink counter is free-running and independent of the scan counter.
//    A digit whose blink[i]=1 is blanked (segments and dp off) while phase=1; its anode stays driven.
//  - enable=0: segments and dp forced off in DRIVE; scanning, shadow reload and frame_sync continue.
//  - colon=1: dp of digit 1 is lit regardless of dp[1]; it is still subject to blink[1] and enable.
//  - Reset mid-slot: everything returns to reset values immediately; the first frame uses shadow=0.
//  - pio_word is synchronous to clk_clk; no input synchroniser.
// CONFIGURATION
//  SEG7_HEX_DECODE_EN defined: nibbles A-F decode to A,b,C,d,E,F glyphs.
//  Undefined: nibbles A-F give a blank digit (seg_n=7'h7F); 0-9 are unchanged.
// STRUCTURE
//  seg7_pkg: glyph constants (SEG_0..SEG_F, SEG_BLANK), field offsets (DIG_LSB, DP_LSB,
//    BLINK_LSB, COLON_BIT, EN_BIT), FSM state enum {BLANK, DRIVE}.
//  Sub-module seg7_decoder: combinational nibble->7'b segment map, honouring SEG7_HEX_DECODE_EN.
//  Top level: scan counter/FSM, blink divider, shadow register, output registers.
// TESTING (CLK_HZ=1000, DIGIT_HZ=100 -> SLOT=10, DEAD_CYCLES=2, BLINK_HZ=5 -> half-period 100)
//  1 Reset held, then released -> an_n=F, seg_n=7F, dp_n=1. First frame blank (shadow=0 => "0000" only
//    after frame_sync if word=0). frame_sync first pulses at cycle 40 after release.
//  2 pio_word=0x0200_1234, check digit 0 slot -> an_n=E for 8 of 10 cycles, seg_n=~SEG_4.
//    Digit 3 -> an_n=7, seg_n=~SEG_1. Dead-time gap between slots is 2 cycles.
//  3 Change pio_word mid-frame from 0x0200_1234 to 0x0200_5678 -> remaining slots still show 1234;
//    5678 appears only after the next frame_sync.
//  4 pio_word=0x0310_0000 (blink d0, colon, enable) -> digit 0 segments alternate every 100 cycles.
//    Digit 1 dp_n=0 on every DRIVE slot.
//  5 pio_word=0x0000_8888 (enable=0) -> an_n keeps scanning, seg_n=7F and dp_n=1 throughout.
//  6 pio_word=0x0200_00AF -> with SEG7_HEX_DECODE_EN: digits show F and A.
//    Without it: digits 0 and 1 blank, digits 2 and 3 show 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 4-digit 7-segment scan driver:
//   - active-high glyph constants, bit order g..a (bit 6 = g, bit 0 = a)
//   - bit offsets of the fields inside the packed PIO word
//   - scan FSM state type
// No ports (package).
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;  // lower-case b
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;  // lower-case d
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Field layout of the PIO word
    localparam int DIG_LSB   = 0;   // [15:0]  nibble i = digit i
    localparam int DP_LSB    = 16;  // [19:16] dp[i]
    localparam int BLINK_LSB = 20;  // [23:20] blink[i]
    localparam int COLON_BIT = 24;
    localparam int EN_BIT    = 25;
    localparam int WORD_USED = 26;  // bits [31:26] carry nothing for us

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational nibble -> active-high segment pattern (g..a).
// Build option: SEG7_HEX_DECODE_EN
//   defined   : nibbles A-F show A, b, C, d, E, F
//   undefined : nibbles A-F show a blank digit; 0-9 unchanged
// Ports:
//   nibble_i  in  4  value to display
//   seg_o     out 7  segments g..a, 1 = lit
// -----------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
`ifdef SEG7_HEX_DECODE_EN
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
`endif
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Consumer of the NIOS 32-bit 7-segment PIO export. The word is snapshotted
// into a shadow register once per frame (digit 3 -> 0 wrap), so a frame never
// mixes old and new digits. Each digit slot starts with DEAD_CYCLES of all
// anodes off to stop ghosting, then drives one anode of a common-anode display.
// Blink, decimal points, colon (dp of digit 1) and global enable are applied
// from the shadow word. Every pin is registered, one cycle behind FSM state.
// Build option: SEG7_HEX_DECODE_EN (see seg7_decoder) selects hex glyphs A-F.
// Parameters:
//   CLK_HZ, DIGIT_HZ : SLOT = CLK_HZ/DIGIT_HZ cycles per digit
//   DEAD_CYCLES      : blank cycles at slot start, must be < SLOT
//   BLINK_HZ         : blink phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
// Ports:
//   clk_clk        in   1   system clock
//   reset_reset_n  in   1   asynchronous active-low reset
//   pio_word       in   32  packed digits/dp/blink/colon/enable
//   seg_n          out  7   segments g..a, active-low
//   dp_n           out  1   decimal point, active-low
//   an_n           out  4   anodes, active-low, one-hot or all-off
//   frame_sync     out  1   one-cycle pulse when the shadow word reloads
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DIGIT_HZ    = 4_000,
    parameter int DEAD_CYCLES = 64,
    parameter int BLINK_HZ    = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] pio_word,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_sync
);

    localparam int SLOT  = CLK_HZ / DIGIT_HZ;
    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] DEAD_VAL  = CNT_W'(DEAD_CYCLES);
    localparam logic [BLK_W-1:0] HALF_LAST = BLK_W'(HALF - 1);

    // Scan state
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           digit_q, digit_d;
    scan_state_e          state_q, state_d;
    logic [WORD_USED-1:0] shadow_q, shadow_d;
    logic                 frame_end;

    // Blink divider
    logic [BLK_W-1:0]     blk_q, blk_d;
    logic                 phase_q, phase_d;

    // Output registers
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [3:0]           an_q, an_d;
    logic                 fs_q, fs_d;

    logic [6:0]           glyph;
    logic [3:0]           nibble;
    logic                 blanked;
    logic                 dp_on;
    logic                 unused_hi;

    assign unused_hi = ^pio_word[31:WORD_USED];

    // Counter, digit index and FSM state advance together; state is derived
    // from the next count so state_q always matches cnt_q.
    always_comb begin
        frame_end = (cnt_q == SLOT_LAST) && (digit_q == 2'd3);
        if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            digit_d = digit_q;
        end
        state_d  = (cnt_d >= DEAD_VAL) ? DRIVE : BLANK;
        shadow_d = frame_end ? pio_word[WORD_USED-1:0] : shadow_q;
    end

    always_comb begin
        if (blk_q == HALF_LAST) begin
            blk_d   = '0;
            phase_d = ~phase_q;
        end else begin
            blk_d   = blk_q + BLK_W'(1);
            phase_d = phase_q;
        end
    end

    assign nibble = shadow_q[DIG_LSB + 4 * int'(digit_q) +: 4];

    seg7_decoder u_decoder (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // Blink blanks segments and dp only; the anode still follows the scan so
    // the duty cycle of the other digits is unaffected.
    always_comb begin
        blanked = !shadow_q[EN_BIT]
                  || (shadow_q[BLINK_LSB + int'(digit_q)] && phase_q);
        dp_on   = shadow_q[DP_LSB + int'(digit_q)]
                  || (shadow_q[COLON_BIT] && (digit_q == 2'd1));
        an_d    = 4'hF;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (state_q == DRIVE) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = blanked ? 7'h7F : ~glyph;
            dp_d  = ~(dp_on && !blanked);
        end
        fs_d = frame_end;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q    <= '0;
            digit_q  <= 2'd0;
            state_q  <= BLANK;
            shadow_q <= '0;
            blk_q    <= '0;
            phase_q  <= 1'b0;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            an_q     <= 4'hF;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            blk_q    <= blk_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign an_n       = an_q;
    assign frame_sync = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Bench for seg7_scan_driver with SLOT=10, DEAD_CYCLES=2, blink half-period 100.
// The reference model works from the cycle index since reset release: slot,
// digit and blink phase are plain divisions of that index, and the shadow word
// is the value of pio_word at the last multiple of the 40-cycle frame.
// Honours SEG7_HEX_DECODE_EN for the expected glyphs of nibbles A-F.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int SLOT  = 10;
    localparam int DEAD  = 2;
    localparam int HALF  = 100;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pio_word;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_sync;

    int          checks = 0;
    int          errors = 0;
    int          n;            // clock edges since reset release
    logic [31:0] m_shadow;     // model of the displayed word
    logic [6:0]  glyph [16];   // active-high g..a

    seg7_scan_driver #(
        .CLK_HZ      (1000),
        .DIGIT_HZ    (100),
        .DEAD_CYCLES (DEAD),
        .BLINK_HZ    (5)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_word      (pio_word),
        .seg_n         (seg_n),
        .dp_n          (dp_n),
        .an_n          (an_n),
        .frame_sync    (frame_sync)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h n=%0d t=%0t", tag, got, exp, n, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_seg"}, 32'(seg_n), 32'h7F);
        check_eq({tag, "_dp"},  32'(dp_n), 32'h1);
        check_eq({tag, "_an"},  32'(an_n), 32'hF);
        check_eq({tag, "_fs"},  32'(frame_sync), 32'h0);
    endtask

    // One clock with pio_word = w, then compare all outputs to the model.
    task automatic step(input logic [31:0] w);
        int         k, cnt, dig, phase;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fs;
        @(negedge clk);
        pio_word = w;
        @(posedge clk);
        #1;
        n++;
        // pins after edge n show the internal state reached after edge n-1
        k     = n - 1;
        cnt   = k % SLOT;
        dig   = (k / SLOT) % 4;
        phase = (k / HALF) % 2;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (cnt >= DEAD) begin
            e_an = 4'hF ^ (4'h1 << dig);
            if (m_shadow[25] && !(m_shadow[20 + dig] && phase == 1)) begin
                e_seg = ~glyph[m_shadow[4 * dig +: 4]];
                e_dp  = !(m_shadow[16 + dig] || (dig == 1 && m_shadow[24]));
            end
        end
        e_fs = (n % FRAME == 0);
        check_eq("an_n",  32'(an_n),  32'(e_an));
        check_eq("seg_n", 32'(seg_n), 32'(e_seg));
        check_eq("dp_n",  32'(dp_n),  32'(e_dp));
        check_eq("frame_sync", 32'(frame_sync), 32'(e_fs));
        if (n % FRAME == 0) m_shadow = w;
    endtask

    // Asynchronous reset at an arbitrary point inside a clock period.
    task automatic apply_reset(input int hold);
        @(posedge clk);
        #($urandom_range(1, 7));
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (hold) @(posedge clk);
        #1;
        check_reset_vals("rst_hold");
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        n        = 0;
        m_shadow = 32'h0;
    endtask

    initial begin
        glyph[0]  = 7'b0111111; glyph[1]  = 7'b0000110;
        glyph[2]  = 7'b1011011; glyph[3]  = 7'b1001111;
        glyph[4]  = 7'b1100110; glyph[5]  = 7'b1101101;
        glyph[6]  = 7'b1111101; glyph[7]  = 7'b0000111;
        glyph[8]  = 7'b1111111; glyph[9]  = 7'b1101111;
`ifdef SEG7_HEX_DECODE_EN
        glyph[10] = 7'b1110111; glyph[11] = 7'b1111100;
        glyph[12] = 7'b0111001; glyph[13] = 7'b1011110;
        glyph[14] = 7'b1111001; glyph[15] = 7'b1110001;
`else
        for (int i = 10; i < 16; i++) glyph[i] = 7'b0000000;
`endif

        // clock/reset
        rst_n    = 1'b0;
        pio_word = 32'h0;
        n        = 0;
        m_shadow = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_init");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // first frame blank, then 1234 after the first frame_sync at n=40
        for (int i = 0; i < 200; i++) step(32'h0200_1234);
        // mid-frame change must not tear the current frame
        for (int i = 0; i < 15; i++) step(32'h0200_1234);
        for (int i = 0; i < 100; i++) step(32'h0200_5678);
        // blink digit 0, colon, enable
        for (int i = 0; i < 450; i++) step(32'h0310_0000);
        // enable off, scanning continues
        for (int i = 0; i < 100; i++) step(32'h0000_8888);
        // hex nibbles
        for (int i = 0; i < 100; i++) step(32'h0200_00AF);

        // randomized words, run lengths and mid-slot resets
        for (int r = 0; r < 30; r++) begin
            logic [31:0] w;
            int          len;
            w   = $urandom;
            len = $urandom_range(5, 150);
            for (int i = 0; i < len; i++) step(w);
            if ($urandom_range(0, 3) == 0) apply_reset($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
